clap_detector: RTL and testbench

- Upstream of the clap counter: turns the FFT magnitude stream into clean, single-cycle clap events.
- Per FFT frame, tracks the peak magnitude inside a programmable bin band and compares it against high/low hysteresis thresholds.
- Emits one pulse per clap and enforces a refractory holdoff, so one loud clap spanning several frames counts once.

---
 rtl/clap_pkg.sv | 7 +
 rtl/clap_if.sv | 14 +
 rtl/band_peak_tracker.sv | 45 ++++
 rtl/clap_detector.sv | 88 ++++++++
 tb/tb_clap_detector.sv | 115 +++++++++++
 5 files changed

// File: rtl/clap_pkg.sv
// clap_pkg: shared state encoding and default widths/thresholds for the clap detector.
package clap_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] THR_HIGH_DEF = 16'h8000;
  localparam logic [DATA_W-1:0] THR_LOW_DEF = 16'h2000;
  typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, HOLDOFF = 2'd2} state_t;
endpackage

// File: rtl/clap_if.sv
// clap_if: magnitude stream in, clap events and debug status out.
// slave: mag_in/mag_valid/mag_last in; clap_pulse/peak_mag/frame_done/state_dbg out.
// master: the mirror image, for the stream source.
interface clap_if #(parameter int DATA_W = clap_pkg::DATA_W);
  logic [DATA_W-1:0] mag_in;
  logic mag_valid;
  logic mag_last;
  logic clap_pulse;
  logic [DATA_W-1:0] peak_mag;
  logic frame_done;
  logic [1:0] state_dbg;
  modport master (output mag_in, mag_valid, mag_last, input clap_pulse, peak_mag, frame_done, state_dbg);
  modport slave (input mag_in, mag_valid, mag_last, output clap_pulse, peak_mag, frame_done, state_dbg);
endinterface

// File: rtl/band_peak_tracker.sv
// band_peak_tracker: per-frame peak magnitude over bins BIN_LO..BIN_HI.
// Ports: clk, rst_n (async low); i_mag/i_valid/i_last stream in;
// o_peak = band peak of last completed frame, o_frame_done = one-cycle update strobe.
module band_peak_tracker
  import clap_pkg::*;
#(
  parameter int DATA_W = clap_pkg::DATA_W,
  parameter int BIN_W = 10,
  parameter int BIN_LO = 8,
  parameter int BIN_HI = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DATA_W-1:0] i_mag,
  input  logic i_valid,
  input  logic i_last,
  output logic [DATA_W-1:0] o_peak,
  output logic o_frame_done
);
  logic [BIN_W-1:0] r_idx;
  logic [DATA_W-1:0] r_run, r_peak;
  logic r_done;
  logic w_in_band;
  logic [DATA_W-1:0] w_run_nxt;
  assign w_in_band = r_idx >= BIN_W'(BIN_LO) && r_idx <= BIN_W'(BIN_HI);
  // strict > so ties keep the earlier value; includes the last bin of the frame
  assign w_run_nxt = (i_valid && w_in_band && i_mag > r_run) ? i_mag : r_run;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_run <= '0;
      r_peak <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_valid && i_last;
      if (i_valid) r_idx <= i_last ? '0 : (&r_idx ? r_idx : r_idx + 1'b1);
      if (i_valid && i_last) begin
        r_peak <= w_run_nxt;
        r_run <= '0;
      end else r_run <= w_run_nxt;
    end
  end
  assign o_peak = r_peak;
  assign o_frame_done = r_done;
endmodule

// File: rtl/clap_detector.sv
// clap_detector: hysteresis/holdoff FSM turning per-frame band peaks into single clap pulses.
// Ports: clk, rst_n (async low); bus (clap_if.slave): magnitude stream in,
// clap_pulse/peak_mag/frame_done/state_dbg out.
module clap_detector
  import clap_pkg::*;
#(
  parameter int DATA_W = clap_pkg::DATA_W,
  parameter int BIN_W = 10,
  parameter int BIN_LO = 8,
  parameter int BIN_HI = 200,
  parameter logic [DATA_W-1:0] THR_HIGH = THR_HIGH_DEF,
  parameter logic [DATA_W-1:0] THR_LOW = THR_LOW_DEF,
  parameter int ATTACK_FRAMES = 2,
  parameter int HOLDOFF_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  clap_if.slave bus
);
  localparam int LW = $clog2(ATTACK_FRAMES + 1);
  localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
  logic [DATA_W-1:0] w_peak;
  logic w_done, w_loud, w_quiet;
  logic [LW-1:0] r_loud, w_loud_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  state_t r_state;
  logic r_pulse;
  band_peak_tracker #(.DATA_W(DATA_W), .BIN_W(BIN_W), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI)) u_peak (
    .clk(clk),
    .rst_n(rst_n),
    .i_mag(bus.mag_in),
    .i_valid(bus.mag_valid),
    .i_last(bus.mag_last),
    .o_peak(w_peak),
    .o_frame_done(w_done)
  );
  assign w_loud = w_peak >= THR_HIGH;
  assign w_quiet = w_peak < THR_LOW;
  assign w_loud_nxt = r_loud + 1'b1;
  assign w_hold_nxt = (r_hold >= HW'(HOLDOFF_FRAMES)) ? r_hold : r_hold + 1'b1;
  // evaluated once per completed frame; the holdoff exit uses the count including this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_loud <= '0;
      r_hold <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_done) begin
        case (r_state)
          IDLE: if (w_loud) begin
            if (ATTACK_FRAMES <= 1) begin
              r_state <= HOLDOFF;
              r_pulse <= 1'b1;
              r_hold <= '0;
            end else begin
              r_state <= ATTACK;
              r_loud <= LW'(1);
            end
          end
          ATTACK: if (!w_loud) begin
            r_state <= IDLE;
            r_loud <= '0;
          end else if (w_loud_nxt >= LW'(ATTACK_FRAMES)) begin
            r_state <= HOLDOFF;
            r_pulse <= 1'b1;
            r_hold <= '0;
            r_loud <= '0;
          end else r_loud <= w_loud_nxt;
          HOLDOFF: begin
            r_hold <= w_hold_nxt;
            if (w_hold_nxt >= HW'(HOLDOFF_FRAMES) && w_quiet) r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_loud <= '0;
            r_hold <= '0;
          end
        endcase
      end
    end
  end
  assign bus.clap_pulse = r_pulse;
  assign bus.peak_mag = w_peak;
  assign bus.frame_done = w_done;
  assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_clap_detector.sv
// tb_clap_detector: directed frame sequences with hand-computed peaks, states and pulse counts.
module tb_clap_detector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int fd_cnt = 0;
  int dbl = 0;
  logic prev_pulse = 1'b0;
  clap_if #(.DATA_W(16)) bus ();
  clap_detector dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.clap_pulse) pulse_cnt++;
    if (bus.clap_pulse && prev_pulse) dbl++;
    if (bus.frame_done) fd_cnt++;
    prev_pulse = bus.clap_pulse;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input int n, input logic [15:0] fill, input int i1, input logic [15:0] v1,
                       input int i2, input logic [15:0] v2, input logic [15:0] exp_pk);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      bus.mag_valid = 1'b1;
      bus.mag_in = (b == i1) ? v1 : (b == i2) ? v2 : fill;
      bus.mag_last = (b == n - 1);
    end
    @(negedge clk);
    bus.mag_valid = 1'b0;
    bus.mag_last = 1'b0;
    chk("frame_done", 32'(bus.frame_done), 32'd1);
    chk("peak_mag", 32'(bus.peak_mag), 32'(exp_pk));
    @(negedge clk);
  endtask
  task automatic fill_frame(input logic [15:0] fill, input logic [1:0] exp_st);
    frame(16, fill, -1, 16'h0, -1, 16'h0, fill);
    chk("state", 32'(bus.state_dbg), 32'(exp_st));
  endtask
  initial begin
    bus.mag_in = '0;
    bus.mag_valid = 1'b0;
    bus.mag_last = 1'b0;
    #1;
    chk("rst_pulse", 32'(bus.clap_pulse), 32'd0);
    chk("rst_peak", 32'(bus.peak_mag), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      frame(256, 16'h1000, -1, 16'h0, -1, 16'h0, 16'h1000);
      chk("fd_cnt", 32'(fd_cnt), 32'(k));
      chk("quiet_state", 32'(bus.state_dbg), 32'd0);
    end
    chk("no_pulse", 32'(pulse_cnt), 32'd0);
    frame(256, 16'h0, 7, 16'hFFFF, 201, 16'hFFFF, 16'h0);
    frame(256, 16'h0, 8, 16'h1234, 200, 16'h1235, 16'h1235);
    frame(100, 16'h0, 99, 16'h4321, -1, 16'h0, 16'h4321);
    chk("edge_state", 32'(bus.state_dbg), 32'd0);
    frame(64, 16'h0, 5, 16'hFFFF, 50, 16'h9000, 16'h9000);
    chk("attack_state", 32'(bus.state_dbg), 32'd1);
    frame(64, 16'h0, 5, 16'hFFFF, 50, 16'h9000, 16'h9000);
    chk("clap_pulse_hi", 32'(bus.clap_pulse), 32'd1);
    chk("holdoff_state", 32'(bus.state_dbg), 32'd2);
    @(negedge clk);
    chk("clap_pulse_lo", 32'(bus.clap_pulse), 32'd0);
    for (int k = 1; k <= 8; k++) fill_frame(16'h0100, (k == 8) ? 2'd0 : 2'd2);
    chk("pulse_cnt1", 32'(pulse_cnt), 32'd1);
    fill_frame(16'h9000, 2'd1);
    fill_frame(16'h0000, 2'd0);
    chk("single_loud", 32'(pulse_cnt), 32'd1);
    fill_frame(16'hA000, 2'd1);
    fill_frame(16'hA000, 2'd2);
    for (int k = 0; k < 10; k++) fill_frame(16'hA000, 2'd2);
    fill_frame(16'h2000, 2'd2);
    fill_frame(16'h1FFF, 2'd0);
    chk("pulse_cnt2", 32'(pulse_cnt), 32'd2);
    fill_frame(16'h7FFF, 2'd0);
    fill_frame(16'h8000, 2'd1);
    fill_frame(16'h8000, 2'd2);
    for (int k = 1; k <= 8; k++) fill_frame(16'h0000, (k == 8) ? 2'd0 : 2'd2);
    chk("pulse_cnt3", 32'(pulse_cnt), 32'd3);
    fill_frame(16'h9000, 2'd1);
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      bus.mag_valid = 1'b1;
      bus.mag_in = 16'hFFFF;
      bus.mag_last = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(bus.state_dbg), 32'd0);
    chk("async_peak", 32'(bus.peak_mag), 32'd0);
    chk("async_done", 32'(bus.frame_done), 32'd0);
    chk("async_pulse", 32'(bus.clap_pulse), 32'd0);
    bus.mag_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frame(16, 16'h1000, 8, 16'h0800, -1, 16'h0, 16'h1000);
    chk("post_rst_state", 32'(bus.state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    chk("pulse_total", 32'(pulse_cnt), 32'd3);
    chk("no_double", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
